enemy_pool: RTL and testbench
=============================

# enemy_pool

Parametrised multi-enemy controller that owns up to N_ENEMIES walking enemies, each with its own position, direction, falling velocity and squish animation. It sits beside the Mario controller and the level/collision map: spawn requests arrive from the level scroller, per-slot collision polls come from the tile map, and the pool produces a merged draw hit, a Mario-kill flag and stomp pulses for the score logic. It adds gravity, a timed squish state, a spawn handshake and multi-channel arbitration.

## Interface
- N_ENEMIES, 4: number of slots (1–8).
- X_SIZE, 10'd20 / Y_SIZE, 10'd20: half-width / half-height.
- X_MIN, 10'd120 / X_MAX, 10'd519 / Y_MAX, 10'd439: playfield bounds.
- X_STEP, 10'd1: walk speed, pixels/frame.
- FALL_MAX, 10'd4: terminal fall speed, pixels/frame.
- SQUISH_FRAMES, 8'd30: frames a squished enemy stays visible.
- Clk  in  1  system clock; the block's only clock.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_clk  in  1  vertical-sync-rate strobe, asynchronous level.
- Shift  in  1  screen scrolled; all live slots move left 40 px this frame.
- spawn_valid  in  1  spawn request.
- spawn_ready  out  1  at least one FREE slot.
- spawnX, spawnY  in  10 each  spawn foot position.
- Mario_X_Pos, Mario_Y_Pos  in  10 each  Mario centre (half-size 20).
- Poll_left, Poll_right, Poll_down  in  3*N_ENEMIES each  per-slot tile polls, slot i at [3i+2:3i]; nonzero = solid.
- DrawX, DrawY  in  10 each  current pixel.
- draw_is_enemy  out  1  pixel hits a visible slot.
- draw_slot  out  $clog2(N_ENEMIES)  lowest-index slot hit.
- draw_squished  out  1  hit slot is SQUISHED.
- alive_mask  out  N_ENEMIES  slot in WALK or FALL.
- stomp  out  1  one-Clk pulse per stomped enemy frame.
- kill_Mario  out  1  sticky Mario-kill flag.
- kill_clear  in  1  clears kill_Mario.

## Operation
- Per-slot states: FREE, WALK, FALL, SQUISHED.
- Reset: every slot FREE, X/Y/motion 0, squish counter 0; kill_Mario 0, stomp 0, spawn_ready 1, alive_mask 0, draw outputs 0.
- Spawn: on spawn_valid && spawn_ready, the lowest-index FREE slot takes X=spawnX, Y=spawnY−Y_SIZE, X motion −X_STEP (two's complement), Y motion 0, state FALL.
- Frame update, per non-FREE slot, in priority order:
  1. Stomp: Mario_Y_Pos+20 == Y−Y_SIZE and X−X_SIZE ≤ Mario_X_Pos < X+X_SIZE → SQUISHED, counter = SQUISH_FRAMES, stomp pulses.
  2. Side contact (WALK/FALL only): |Mario_X_Pos−X| < X_SIZE+20 and |Mario_Y_Pos−Y| < Y_SIZE+20 → kill_Mario set.
  3. Despawn: X+X_SIZE < X_MIN, or Y−Y_SIZE > Y_MAX → FREE.
  4. Motion, WALK/FALL:
     - Poll_left nonzero → direction +X_STEP.
     - Poll_right nonzero or X+X_SIZE ≥ X_MAX → direction −X_STEP; right wins.
     - Poll_down zero → FALL, Y motion += 1, saturating at FALL_MAX.
     - Poll_down nonzero → WALK, Y motion 0.
     - X += motion, or X −= 40 when Shift. Y += Y motion.
  5. SQUISHED: counter decrements; at 0 → FREE. Shift also applies.
- All arithmetic is 10-bit modular; negative motion is two's complement.
- Between frame updates, slot registers hold.

## Timing
- frame_clk is double-flopped, then edge-detected. The update executes in the Clk cycle after the registered edge, so latency is 3 Clk from the frame_clk rise.
- Spawn accept is visible in registers 1 Clk after the handshake. spawn_ready is combinational from the slot states.
- Spawn and frame update in the same cycle: the spawning slot loads spawn values and skips that update; other slots update normally.
- Several stomps in one frame: stomp pulses once, 1 Clk.
- Stomp and side contact on the same slot: stomp wins, no kill.
- kill_clear and a new kill in the same cycle: the kill wins.
- Draw outputs are combinational from the slot registers and DrawX/DrawY.
- SQUISHED slots draw only the lower half, Y ≤ DrawY < Y+Y_SIZE.
- Reset_n asserted mid-frame: immediate return to reset values; any in-flight edge is discarded.

## Structure
- enemy_pkg: slot_state_t enum, the 20-px Mario half-size constant, the 40-px shift constant.
- Sub-module enemy_slot, instantiated N_ENEMIES times, holds one slot's state machine and motion.
- enemy_pool holds edge detection, spawn allocation, stomp/kill merge and the draw priority mux.

## Test plan
- Reset, then spawn at (300,400) → slot 0 at X=300, Y=380, FALL, spawn_ready=1; fourth spawn fills slot 3, spawn_ready=0.
- Poll_down=0 for 6 frames → Y motion 1,2,3,4,4,4; Y=380+18; Poll_down=3'b001 → WALK, X decrements 1 per frame.
- Poll_left nonzero on slot 1 → +1 motion next frame; Poll_left and Poll_right both nonzero → −1.
- Mario at (300,340) over enemy at (300,380) → stomp for 1 Clk, SQUISHED drawn at DrawY 380–399 only, FREE after 30 frames.
- Mario at (262,380), enemy at (300,380) → kill_Mario=1, held until kill_clear.
- spawn_valid on the frame-update cycle, plus Shift → new slot at spawn values, existing slots X−40; enemy with X=99 → FREE.

Source files
------------

// File: rtl/enemy_pkg.sv
// enemy_pkg: shared slot states and Mario/scroll geometry constants
package enemy_pkg;
  typedef enum logic [1:0] {FREE, WALK, FALL, SQUISHED} slot_state_t;
  localparam logic [9:0] MARIO_HALF = 10'd20;
  localparam logic [9:0] SHIFT_PX = 10'd40;
endpackage

// File: rtl/enemy_slot.sv
// enemy_slot: one enemy's state machine, gravity, walking, squish timer and draw box
module enemy_slot
  import enemy_pkg::*;
#(
  parameter logic [9:0] X_SIZE = 10'd20,
  parameter logic [9:0] Y_SIZE = 10'd20,
  parameter logic [9:0] X_MIN = 10'd120,
  parameter logic [9:0] X_MAX = 10'd519,
  parameter logic [9:0] Y_MAX = 10'd439,
  parameter logic [9:0] X_STEP = 10'd1,
  parameter logic [9:0] FALL_MAX = 10'd4,
  parameter logic [7:0] SQUISH_FRAMES = 8'd30
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        tick,
  input  logic        Shift,
  input  logic        load,
  input  logic [9:0]  spawnX,
  input  logic [9:0]  spawnY,
  input  logic [9:0]  Mario_X_Pos,
  input  logic [9:0]  Mario_Y_Pos,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [2:0]  poll_left,
  input  logic [2:0]  poll_right,
  input  logic [2:0]  poll_down,
  output slot_state_t state,
  output logic        stomp_hit,
  output logic        kill_hit,
  output logic        hit
);
  logic [9:0] x, y, xm, ym, dx, dy, xm_n, ym_n;
  logic [7:0] cnt;
  logic live, squished, despawn;
  assign live = state == WALK || state == FALL;
  assign squished = state == SQUISHED;
  assign dx = Mario_X_Pos - x;
  assign dy = Mario_Y_Pos - y;
  assign stomp_hit = state != FREE && Mario_Y_Pos + MARIO_HALF == y - Y_SIZE &&
                     x - X_SIZE <= Mario_X_Pos && Mario_X_Pos < x + X_SIZE;
  assign kill_hit = live && !stomp_hit && (dx[9] ? -dx : dx) < X_SIZE + MARIO_HALF &&
                    (dy[9] ? -dy : dy) < Y_SIZE + MARIO_HALF;
  assign despawn = x + X_SIZE < X_MIN || y - Y_SIZE > Y_MAX;
  // right-side blocking overrides a left-side bounce
  assign xm_n = (|poll_right || x + X_SIZE >= X_MAX) ? -X_STEP : |poll_left ? X_STEP : xm;
  assign ym_n = |poll_down ? 10'd0 : ym >= FALL_MAX ? FALL_MAX : ym + 10'd1;
  assign hit = (live || squished) && DrawX >= x - X_SIZE && DrawX < x + X_SIZE &&
               DrawY >= (squished ? y : y - Y_SIZE) && DrawY < y + Y_SIZE;
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= FREE;
      x <= '0;
      y <= '0;
      xm <= '0;
      ym <= '0;
      cnt <= '0;
    end else if (load) begin
      state <= FALL;
      x <= spawnX;
      y <= spawnY - Y_SIZE;
      xm <= -X_STEP;
      ym <= '0;
    end else if (tick && state != FREE) begin
      if (stomp_hit) begin
        state <= SQUISHED;
        cnt <= SQUISH_FRAMES;
      end else if (despawn) begin
        state <= FREE;
      end else if (squished) begin
        cnt <= cnt - 8'd1;
        state <= cnt == 8'd1 ? FREE : SQUISHED;
        x <= Shift ? x - SHIFT_PX : x;
      end else begin
        state <= |poll_down ? WALK : FALL;
        xm <= xm_n;
        ym <= ym_n;
        x <= Shift ? x - SHIFT_PX : x + xm_n;
        y <= y + ym_n;
      end
    end
  end
endmodule

// File: rtl/enemy_pool.sv
// enemy_pool: frame tick, spawn allocation, stomp/kill merge and draw priority over N enemy slots
module enemy_pool
  import enemy_pkg::*;
#(
  parameter int N_ENEMIES = 4,
  parameter logic [9:0] X_SIZE = 10'd20,
  parameter logic [9:0] Y_SIZE = 10'd20,
  parameter logic [9:0] X_MIN = 10'd120,
  parameter logic [9:0] X_MAX = 10'd519,
  parameter logic [9:0] Y_MAX = 10'd439,
  parameter logic [9:0] X_STEP = 10'd1,
  parameter logic [9:0] FALL_MAX = 10'd4,
  parameter logic [7:0] SQUISH_FRAMES = 8'd30,
  localparam int SW = N_ENEMIES > 1 ? $clog2(N_ENEMIES) : 1
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   frame_clk,
  input  logic                   Shift,
  input  logic                   spawn_valid,
  output logic                   spawn_ready,
  input  logic [9:0]             spawnX,
  input  logic [9:0]             spawnY,
  input  logic [9:0]             Mario_X_Pos,
  input  logic [9:0]             Mario_Y_Pos,
  input  logic [3*N_ENEMIES-1:0] Poll_left,
  input  logic [3*N_ENEMIES-1:0] Poll_right,
  input  logic [3*N_ENEMIES-1:0] Poll_down,
  input  logic [9:0]             DrawX,
  input  logic [9:0]             DrawY,
  output logic                   draw_is_enemy,
  output logic [SW-1:0]          draw_slot,
  output logic                   draw_squished,
  output logic [N_ENEMIES-1:0]   alive_mask,
  output logic                   stomp,
  output logic                   kill_Mario,
  input  logic                   kill_clear
);
  slot_state_t st [N_ENEMIES];
  logic [N_ENEMIES-1:0] free_v, load, stomp_v, kill_v, hit_v, sq_v;
  logic [2:0] fsync;
  logic tick;
  // two flops of synchronisation, the third holds the previous level for rise detection
  assign tick = fsync[1] & ~fsync[2];
  assign spawn_ready = |free_v;
  assign draw_is_enemy = |hit_v;
  for (genvar i = 0; i < N_ENEMIES; i++) begin : g_slot
    enemy_slot #(
      .X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE), .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MAX(Y_MAX),
      .X_STEP(X_STEP), .FALL_MAX(FALL_MAX), .SQUISH_FRAMES(SQUISH_FRAMES)
    ) u_slot (
      .Clk(Clk), .Reset_n(Reset_n), .tick(tick), .Shift(Shift), .load(load[i]),
      .spawnX(spawnX), .spawnY(spawnY), .Mario_X_Pos(Mario_X_Pos), .Mario_Y_Pos(Mario_Y_Pos),
      .DrawX(DrawX), .DrawY(DrawY), .poll_left(Poll_left[3*i +: 3]),
      .poll_right(Poll_right[3*i +: 3]), .poll_down(Poll_down[3*i +: 3]),
      .state(st[i]), .stomp_hit(stomp_v[i]), .kill_hit(kill_v[i]), .hit(hit_v[i])
    );
    assign free_v[i] = st[i] == FREE;
    assign sq_v[i] = st[i] == SQUISHED;
    assign alive_mask[i] = st[i] == WALK || st[i] == FALL;
  end
  always_comb begin
    load = '0;
    for (int i = N_ENEMIES - 1; i >= 0; i--)
      if (free_v[i] && spawn_valid) begin
        load = '0;
        load[i] = 1'b1;
      end
  end
  always_comb begin
    draw_slot = '0;
    draw_squished = 1'b0;
    for (int i = N_ENEMIES - 1; i >= 0; i--)
      if (hit_v[i]) begin
        draw_slot = SW'(i);
        draw_squished = sq_v[i];
      end
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fsync <= '0;
      stomp <= 1'b0;
      kill_Mario <= 1'b0;
    end else begin
      fsync <= {fsync[1:0], frame_clk};
      stomp <= tick && |(stomp_v & ~load);
      kill_Mario <= (tick && |(kill_v & ~load)) || (kill_Mario && !kill_clear);
    end
  end
endmodule

// File: tb/tb_enemy_pool.sv
// tb_enemy_pool: directed checks of spawn, gravity, walking, stomp, kill, shift and despawn
module tb_enemy_pool;
  import enemy_pkg::*;
  logic Clk = 1'b0, Reset_n = 1'b0, frame_clk = 1'b0, Shift = 1'b0;
  logic spawn_valid = 1'b0, kill_clear = 1'b0;
  logic [9:0] spawnX = '0, spawnY = '0, Mario_X_Pos = '0, Mario_Y_Pos = '0, DrawX = '0, DrawY = '0;
  logic [11:0] Poll_left = '0, Poll_right = '0, Poll_down = '0;
  logic spawn_ready, draw_is_enemy, draw_squished, stomp, kill_Mario;
  logic [1:0] draw_slot;
  logic [3:0] alive_mask;
  int passed = 0, total = 0, stomp_cnt = 0;
  logic [9:0] ym_exp [6] = '{10'd1, 10'd2, 10'd3, 10'd4, 10'd4, 10'd4};

  enemy_pool dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .Shift(Shift),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready), .spawnX(spawnX), .spawnY(spawnY),
    .Mario_X_Pos(Mario_X_Pos), .Mario_Y_Pos(Mario_Y_Pos), .Poll_left(Poll_left),
    .Poll_right(Poll_right), .Poll_down(Poll_down), .DrawX(DrawX), .DrawY(DrawY),
    .draw_is_enemy(draw_is_enemy), .draw_slot(draw_slot), .draw_squished(draw_squished),
    .alive_mask(alive_mask), .stomp(stomp), .kill_Mario(kill_Mario), .kill_clear(kill_clear)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout required $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    Mario_X_Pos = '0;
    Mario_Y_Pos = '0;
    Poll_left = '0;
    Poll_right = '0;
    Poll_down = 12'h249;
    #1;
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic do_spawn(input logic [9:0] sx, input logic [9:0] sy);
    spawnX = sx;
    spawnY = sy;
    spawn_valid = 1'b1;
    @(negedge Clk);
    spawn_valid = 1'b0;
  endtask

  task automatic frame();
    stomp_cnt = 0;
    frame_clk = 1'b1;
    repeat (6) begin
      @(negedge Clk);
      stomp_cnt += int'(stomp);
    end
    frame_clk = 1'b0;
    repeat (4) begin
      @(negedge Clk);
      stomp_cnt += int'(stomp);
    end
  endtask

  initial begin
    @(negedge Clk);
    @(negedge Clk);
    chk("rst_spawn_ready", spawn_ready, 1);
    chk("rst_alive", alive_mask, 0);
    chk("rst_kill", kill_Mario, 0);
    chk("rst_stomp", stomp, 0);
    chk("rst_draw", draw_is_enemy, 0);
    Reset_n = 1'b1;
    @(negedge Clk);
    do_spawn(10'd300, 10'd400);
    chk("spawn0_x", dut.g_slot[0].u_slot.x, 300);
    chk("spawn0_y", dut.g_slot[0].u_slot.y, 380);
    chk("spawn0_state", dut.g_slot[0].u_slot.state, FALL);
    chk("spawn0_ready", spawn_ready, 1);
    chk("spawn0_alive", alive_mask, 4'b0001);
    do_spawn(10'd200, 10'd400);
    do_spawn(10'd350, 10'd400);
    do_spawn(10'd400, 10'd400);
    chk("full_alive", alive_mask, 4'b1111);
    chk("full_ready", spawn_ready, 0);
    do_spawn(10'd10, 10'd10);
    chk("full_ignore_x", dut.g_slot[0].u_slot.x, 300);
    DrawX = 10'd300;
    DrawY = 10'd380;
    #1;
    chk("draw_hit0", draw_is_enemy, 1);
    chk("draw_slot0", draw_slot, 0);
    chk("draw_sq0", draw_squished, 0);
    DrawX = 10'd340;
    #1;
    chk("draw_slot2", draw_slot, 2);
    // six falling frames with no floor under any slot
    Poll_down = '0;
    for (int f = 0; f < 6; f++) begin
      frame();
      chk("fall_ym", dut.g_slot[0].u_slot.ym, 32'(ym_exp[f]));
    end
    chk("fall_y", dut.g_slot[0].u_slot.y, 398);
    chk("fall_x", dut.g_slot[0].u_slot.x, 294);
    Poll_down = 12'h249;
    frame();
    chk("land_state", dut.g_slot[0].u_slot.state, WALK);
    chk("land_ym", dut.g_slot[0].u_slot.ym, 0);
    chk("land_y", dut.g_slot[0].u_slot.y, 398);
    frame();
    chk("walk_x", dut.g_slot[0].u_slot.x, 292);
    chk("walk_alive", alive_mask, 4'b1111);
    chk("slot1_x", dut.g_slot[1].u_slot.x, 192);
    Poll_left = 12'h010;
    frame();
    chk("left_xm", dut.g_slot[1].u_slot.xm, 1);
    chk("left_x", dut.g_slot[1].u_slot.x, 193);
    Poll_right = 12'h020;
    frame();
    chk("both_xm", dut.g_slot[1].u_slot.xm, 10'h3FF);
    chk("both_x", dut.g_slot[1].u_slot.x, 192);
    // asynchronous reset: slots clear before any clock edge
    Reset_n = 1'b0;
    #1;
    chk("async_rst_alive", alive_mask, 0);
    do_reset();
    do_spawn(10'd300, 10'd400);
    do_spawn(10'd300, 10'd400);
    Mario_X_Pos = 10'd300;
    Mario_Y_Pos = 10'd340;
    frame();
    chk("stomp_pulse_cnt", stomp_cnt, 1);
    chk("stomp_state", dut.g_slot[0].u_slot.state, SQUISHED);
    chk("stomp_no_kill", kill_Mario, 0);
    chk("stomp_alive", alive_mask, 0);
    Mario_X_Pos = '0;
    Mario_Y_Pos = '0;
    DrawX = 10'd300;
    DrawY = 10'd379;
    #1;
    chk("sq_draw_379", draw_is_enemy, 0);
    DrawY = 10'd380;
    #1;
    chk("sq_draw_380", draw_is_enemy, 1);
    chk("sq_draw_flag", draw_squished, 1);
    chk("sq_draw_slot", draw_slot, 0);
    DrawY = 10'd399;
    #1;
    chk("sq_draw_399", draw_is_enemy, 1);
    DrawY = 10'd400;
    #1;
    chk("sq_draw_400", draw_is_enemy, 0);
    DrawY = 10'd390;
    DrawX = 10'd320;
    #1;
    chk("sq_draw_x320", draw_is_enemy, 0);
    DrawX = 10'd280;
    #1;
    chk("sq_draw_x280", draw_is_enemy, 1);
    repeat (29) frame();
    chk("sq_cnt_29", dut.g_slot[0].u_slot.cnt, 1);
    chk("sq_still", draw_is_enemy, 1);
    frame();
    chk("sq_free", dut.g_slot[0].u_slot.state, FREE);
    chk("sq_free1", dut.g_slot[1].u_slot.state, FREE);
    chk("sq_gone", draw_is_enemy, 0);
    do_reset();
    do_spawn(10'd300, 10'd400);
    Mario_X_Pos = 10'd262;
    Mario_Y_Pos = 10'd380;
    frame();
    chk("kill_set", kill_Mario, 1);
    chk("kill_x", dut.g_slot[0].u_slot.x, 299);
    Mario_X_Pos = '0;
    Mario_Y_Pos = '0;
    frame();
    chk("kill_sticky", kill_Mario, 1);
    kill_clear = 1'b1;
    @(negedge Clk);
    kill_clear = 1'b0;
    chk("kill_cleared", kill_Mario, 0);
    do_reset();
    do_spawn(10'd99, 10'd400);
    do_spawn(10'd300, 10'd400);
    frame_clk = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    chk("tick_align", dut.tick, 1);
    Shift = 1'b1;
    spawnX = 10'd250;
    spawnY = 10'd300;
    spawn_valid = 1'b1;
    @(negedge Clk);
    spawn_valid = 1'b0;
    Shift = 1'b0;
    frame_clk = 1'b0;
    repeat (20) @(negedge Clk);
    chk("shift_despawn", dut.g_slot[0].u_slot.state, FREE);
    chk("shift_x1", dut.g_slot[1].u_slot.x, 260);
    chk("shift_state1", dut.g_slot[1].u_slot.state, WALK);
    chk("same_cycle_x2", dut.g_slot[2].u_slot.x, 250);
    chk("same_cycle_y2", dut.g_slot[2].u_slot.y, 280);
    chk("same_cycle_st2", dut.g_slot[2].u_slot.state, FALL);
    chk("shift_alive", alive_mask, 4'b0110);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
